sha256_block_hasher: RTL and testbench
======================================

Name: sha256_block_hasher

Overview:
Parametrised successor to the current single-round SHA-256 hasher. Accepts a stream of 512-bit blocks under a valid/ready handshake and chains intermediate hash values across multi-block messages. Executes ROUNDS_PER_CYCLE rounds per clock and optionally performs a second SHA-256 pass over the digest (double SHA, as used by the miner). Sits between the block/padding front end and the nonce/target comparator.

Parameters:
ROUNDS_PER_CYCLE, 1, rounds unrolled per clock; must divide 64 (1,2,4,8,16,32,64); any other value is an elaboration error. N = 64/ROUNDS_PER_CYCLE.
DOUBLE_HASH_EN, 0, 1 builds the double-SHA path; 0 ignores doubleIn.

Ports:
clk  input  1  clock.
resetN  input  1  synchronous active-low reset.
validIn  input  1  blockIn/flags valid.
readyOut  output  1  block accepted when validIn && readyOut.
firstBlockIn  input  1  block starts a new message.
lastBlockIn  input  1  block ends the message.
doubleIn  input  1  sampled only with lastBlockIn; request double SHA.
blockIn  input  16x32  message block, word 0 first, already padded.
validOut  output  1  hashOut valid.
readyIn  input  1  consumer accepts hashOut when validOut && readyIn.
hashOut  output  8x32  digest H0..H7.
busyOut  output  1  high in Compress/Accumulate/Output.

Behaviour:
- Synchronous reset. One clock; resetN sampled only at the clk edge. While resetN is low at an edge: state<=Idle, validOut=0, hashOut=0, the chain register H is set to IV, and the last/double flags are cleared. readyOut is 0 while resetN is low.
- States: Idle, Compress, Accumulate, Output.
- Idle: readyOut=1.
  - On accept, latch W<=blockIn and latch the last/double flags.
  - If firstBlockIn is high, or the previous message completed, the chain is IV; otherwise the chain is the current H.
  - Working vars <= chain; round counter <= 0. Go to Compress.
- Compress: readyOut=0. Each edge applies ROUNDS_PER_CYCLE rounds with K[j..j+R-1] and the rolling 16-word schedule, then j+=R. After N edges, go to Accumulate.
- Accumulate: one cycle. sum[i] = H_chain[i] + var[i], mod 2^32, per word, combinational. At the edge:
  - Not last: H<=sum, go to Idle.
  - Last, no double (or DOUBLE_HASH_EN=0): hashOut<=sum, validOut<=1, go to Output.
  - Last with double, first pass: W<={sum[0..7], 32'h80000000, six zero words, 32'h00000100}; vars and H<=IV; set the second-pass flag; go to Compress.
  - Second pass: hashOut<=sum, go to Output.
- Output: validOut=1 and hashOut stable until the validOut && readyIn edge. Then validOut<=0, H<=IV, go to Idle. readyOut stays 0 in Output (no overlap).
- Latency from the accepting edge to validOut high: N+1 edges for a single block (65 at R=1, 17 at R=4). Double SHA takes 2(N+1) edges. Each further block in a message adds N+1.
- Boundaries:
  - validIn while readyOut=0 is ignored; the source must hold it.
  - doubleIn without lastBlockIn is ignored.
  - firstBlockIn and lastBlockIn both high marks a one-block message.
  - readyIn held high means validOut lasts exactly one cycle.
  - Reset mid-Compress or mid-Output abandons the work: validOut drops at that edge and no partial digest is emitted.
- All arithmetic is 32-bit, wrapping mod 2^32.

Decomposition:
- Sha256Types package holds:
  - the WorkingVars struct;
  - K[0:63] round constants and IV (moved out of the hasher);
  - the padded-digest constants 32'h80000000 and 32'h00000100;
  - functions Sigma0, Sigma1, sigma0, sigma1, Ch and Maj.
- Sub-module sha256_round: one combinational round plus one schedule step, with inputs vars, W[0:15] and k, and outputs vars and W. A generate loop chains ROUNDS_PER_CYCLE instances between the vars/W registers.

Test Plan:
- Reset, then "abc" single padded block, first+last, R=1 -> hashOut ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad; validOut exactly 65 edges after accept.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" with an idle gap between blocks -> 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1; readyOut=0 throughout compression.
- DOUBLE_HASH_EN=1, "abc" with doubleIn -> 4f8b42c2 2dd3729b 519ba6f6 8d2da7cc 5b2d606d 05daed5a d5128cc0 3e6c6358 after 130 edges at R=1.
- Sweep R in {1,4,64}: empty message (block 80000000, zeros) -> e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855; latency N+1.
- Backpressure: readyIn low for 10 cycles -> validOut and hashOut stable, readyOut=0; validIn pulses during that window are not accepted.
- Reset: resetN low mid-Compress for 1 cycle -> validOut never rises and readyOut=1 after release; a fresh "abc" then gives the correct digest.

Source files
------------

// File: rtl/sha256_block_hasher_pkg.sv
// Shared SHA-256 types, round constants, initial hash value and round helper functions.
package sha256_block_hasher_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_COMPRESS, ST_ACCUM, ST_OUTPUT} state_e;

    typedef struct packed {
        logic [31:0] a, b, c, d, e, f, g, h;
    } work_vars_t;

    typedef logic [15:0][31:0] block_t;   // index 0 is message word 0
    typedef logic [7:0][31:0]  digest_t;  // index 0 is H0

    localparam logic [31:0] PAD_ONE = 32'h80000000;
    localparam logic [31:0] PAD_LEN = 32'h00000100;

    localparam work_vars_t IV = '{a: 32'h6a09e667, b: 32'hbb67ae85, c: 32'h3c6ef372, d: 32'ha54ff53a,
                                  e: 32'h510e527f, f: 32'h9b05688c, g: 32'h1f83d9ab, h: 32'h5be0cd19};

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] Sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] Sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] Ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] Maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic work_vars_t add_vars(input work_vars_t x, input work_vars_t y);
        work_vars_t r;
        r.a = x.a + y.a;  r.b = x.b + y.b;  r.c = x.c + y.c;  r.d = x.d + y.d;
        r.e = x.e + y.e;  r.f = x.f + y.f;  r.g = x.g + y.g;  r.h = x.h + y.h;
        return r;
    endfunction

    function automatic digest_t to_digest(input work_vars_t v);
        digest_t r;
        r[0] = v.a;  r[1] = v.b;  r[2] = v.c;  r[3] = v.d;
        r[4] = v.e;  r[5] = v.f;  r[6] = v.g;  r[7] = v.h;
        return r;
    endfunction

    // Second-pass block: 256-bit digest followed by SHA-256 padding for a 256-bit message.
    function automatic block_t pad_digest(input work_vars_t v);
        block_t r;
        r = '0;
        r[7:0] = to_digest(v);
        r[8]   = PAD_ONE;
        r[15]  = PAD_LEN;
        return r;
    endfunction

endpackage

// File: rtl/sha256_block_hasher_if.sv
// Block-in / digest-out handshake bundle of the SHA-256 block hasher.
interface sha256_block_hasher_if;
    import sha256_block_hasher_pkg::*;

    logic    validIn;
    logic    readyOut;
    logic    firstBlockIn;
    logic    lastBlockIn;
    logic    doubleIn;
    block_t  blockIn;
    logic    validOut;
    logic    readyIn;
    digest_t hashOut;
    logic    busyOut;

    modport slave (
        input  validIn, firstBlockIn, lastBlockIn, doubleIn, blockIn, readyIn,
        output readyOut, validOut, hashOut, busyOut
    );

    modport master (
        output validIn, firstBlockIn, lastBlockIn, doubleIn, blockIn, readyIn,
        input  readyOut, validOut, hashOut, busyOut
    );
endinterface

// File: rtl/sha256_block_hasher_round.sv
// One combinational SHA-256 round plus one step of the rolling 16-word message schedule.
module sha256_round
    import sha256_block_hasher_pkg::*;
(
    input  work_vars_t  vars_i,
    input  block_t      w_i,
    input  logic [31:0] k_i,
    output work_vars_t  vars_o,
    output block_t      w_o
);
    logic [31:0] t1;
    logic [31:0] t2;

    assign t1 = vars_i.h + Sigma1(vars_i.e) + Ch(vars_i.e, vars_i.f, vars_i.g) + k_i + w_i[0];
    assign t2 = Sigma0(vars_i.a) + Maj(vars_i.a, vars_i.b, vars_i.c);

    assign vars_o.a = t1 + t2;
    assign vars_o.b = vars_i.a;
    assign vars_o.c = vars_i.b;
    assign vars_o.d = vars_i.c;
    assign vars_o.e = vars_i.d + t1;
    assign vars_o.f = vars_i.e;
    assign vars_o.g = vars_i.f;
    assign vars_o.h = vars_i.g;

    // Window holds W[t..t+15]; shift down and append W[t+16].
    assign w_o = {sigma1(w_i[14]) + w_i[9] + sigma0(w_i[1]) + w_i[0], w_i[15:1]};
endmodule

// File: rtl/sha256_block_hasher.sv
// SHA-256 block hasher: chains multi-block messages, ROUNDS_PER_CYCLE rounds per clock, optional double SHA.
module sha256_block_hasher
    import sha256_block_hasher_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter int DOUBLE_HASH_EN   = 0
) (
    input logic                  clk,
    input logic                  resetN,
    sha256_block_hasher_if.slave bus
);
    if (ROUNDS_PER_CYCLE < 1 || ROUNDS_PER_CYCLE > 64 || (64 % ROUNDS_PER_CYCLE) != 0) begin : g_bad_rounds
        $error("ROUNDS_PER_CYCLE must divide 64");
    end

    localparam logic [6:0] LAST_ROUND = 7'(64 - ROUNDS_PER_CYCLE);
    localparam logic [6:0] STEP       = 7'(ROUNDS_PER_CYCLE);

    state_e     state_q, state_d;
    logic [6:0] round_q, round_d;
    work_vars_t vars_q, vars_d;
    work_vars_t h_q, h_d;
    block_t     w_q, w_d;
    logic       last_q, last_d;
    logic       double_q, double_d;
    logic       second_q, second_d;
    logic       valid_q, valid_d;
    digest_t    hash_q, hash_d;

    work_vars_t vars_rnd;
    block_t     w_rnd;
    work_vars_t sum;

    for (genvar i = 0; i < ROUNDS_PER_CYCLE; i++) begin : g_rnd
        work_vars_t v_in, v_out;
        block_t     w_in, w_out;
        logic [5:0] kidx;
        if (i == 0) begin : g_head
            assign v_in = vars_q;
            assign w_in = w_q;
        end else begin : g_link
            assign v_in = g_rnd[i-1].v_out;
            assign w_in = g_rnd[i-1].w_out;
        end
        assign kidx = 6'(round_q + 7'(i));
        sha256_round u_round (
            .vars_i (v_in),
            .w_i    (w_in),
            .k_i    (K[kidx]),
            .vars_o (v_out),
            .w_o    (w_out)
        );
    end

    assign vars_rnd = g_rnd[ROUNDS_PER_CYCLE-1].v_out;
    assign w_rnd    = g_rnd[ROUNDS_PER_CYCLE-1].w_out;
    assign sum      = add_vars(h_q, vars_q);

    always_comb begin
        state_d  = state_q;
        round_d  = round_q;
        vars_d   = vars_q;
        h_d      = h_q;
        w_d      = w_q;
        last_d   = last_q;
        double_d = double_q;
        second_d = second_q;
        valid_d  = valid_q;
        hash_d   = hash_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.validIn) begin
                    w_d      = bus.blockIn;
                    last_d   = bus.lastBlockIn;
                    double_d = bus.lastBlockIn && bus.doubleIn && (DOUBLE_HASH_EN != 0);
                    second_d = 1'b0;
                    h_d      = bus.firstBlockIn ? IV : h_q;
                    vars_d   = bus.firstBlockIn ? IV : h_q;
                    round_d  = '0;
                    state_d  = ST_COMPRESS;
                end
            end
            ST_COMPRESS: begin
                vars_d = vars_rnd;
                w_d    = w_rnd;
                if (round_q == LAST_ROUND) state_d = ST_ACCUM;
                else                       round_d = round_q + STEP;
            end
            ST_ACCUM: begin
                if (!last_q) begin
                    h_d     = sum;
                    state_d = ST_IDLE;
                end else if (double_q && !second_q) begin
                    w_d      = pad_digest(sum);
                    vars_d   = IV;
                    h_d      = IV;
                    second_d = 1'b1;
                    round_d  = '0;
                    state_d  = ST_COMPRESS;
                end else begin
                    hash_d  = to_digest(sum);
                    valid_d = 1'b1;
                    state_d = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                if (bus.readyIn) begin
                    valid_d  = 1'b0;
                    h_d      = IV;
                    second_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q  <= ST_IDLE;
            valid_q  <= 1'b0;
            hash_q   <= '0;
            h_q      <= IV;
            last_q   <= 1'b0;
            double_q <= 1'b0;
            second_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            hash_q   <= hash_d;
            h_q      <= h_d;
            last_q   <= last_d;
            double_q <= double_d;
            second_q <= second_d;
        end
    end

    always_ff @(posedge clk) begin
        round_q <= round_d;
        vars_q  <= vars_d;
        w_q     <= w_d;
    end

    assign bus.readyOut = resetN && (state_q == ST_IDLE);
    assign bus.busyOut  = (state_q != ST_IDLE);
    assign bus.validOut = valid_q;
    assign bus.hashOut  = hash_q;
endmodule

// File: tb/tb_sha256_block_hasher.sv
// Bench for sha256_block_hasher: three builds (R=1 with double SHA, R=4, R=64) driven from one vector table.
`timescale 1ns/1ps
module tb_sha256_block_hasher;
    import sha256_block_hasher_pkg::*;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    always #5 clk = ~clk;

    sha256_block_hasher_if if0();
    sha256_block_hasher_if if1();
    sha256_block_hasher_if if2();

    sha256_block_hasher #(.ROUNDS_PER_CYCLE(1),  .DOUBLE_HASH_EN(1)) u_r1  (.clk(clk), .resetN(resetN), .bus(if0));
    sha256_block_hasher #(.ROUNDS_PER_CYCLE(4),  .DOUBLE_HASH_EN(0)) u_r4  (.clk(clk), .resetN(resetN), .bus(if1));
    sha256_block_hasher #(.ROUNDS_PER_CYCLE(64), .DOUBLE_HASH_EN(0)) u_r64 (.clk(clk), .resetN(resetN), .bus(if2));

    logic    vin [3], fst [3], lst [3], dbl [3], rin [3];
    block_t  blk [3];
    logic    rout [3], vout [3], busy [3];
    digest_t hout [3];

    assign if0.validIn = vin[0];  assign if0.firstBlockIn = fst[0];  assign if0.lastBlockIn = lst[0];
    assign if0.doubleIn = dbl[0]; assign if0.blockIn = blk[0];       assign if0.readyIn = rin[0];
    assign if1.validIn = vin[1];  assign if1.firstBlockIn = fst[1];  assign if1.lastBlockIn = lst[1];
    assign if1.doubleIn = dbl[1]; assign if1.blockIn = blk[1];       assign if1.readyIn = rin[1];
    assign if2.validIn = vin[2];  assign if2.firstBlockIn = fst[2];  assign if2.lastBlockIn = lst[2];
    assign if2.doubleIn = dbl[2]; assign if2.blockIn = blk[2];       assign if2.readyIn = rin[2];

    assign rout[0] = if0.readyOut; assign vout[0] = if0.validOut; assign busy[0] = if0.busyOut; assign hout[0] = if0.hashOut;
    assign rout[1] = if1.readyOut; assign vout[1] = if1.validOut; assign busy[1] = if1.busyOut; assign hout[1] = if1.hashOut;
    assign rout[2] = if2.readyOut; assign vout[2] = if2.validOut; assign busy[2] = if2.busyOut; assign hout[2] = if2.hashOut;

    typedef struct {
        int      d;
        block_t  b;
        bit      f;
        bit      l;
        bit      db;
        digest_t exp;
        int      lat;
    } vec_t;

    typedef struct {
        int      d;
        int      id;
        digest_t hash;
        int      lat;
    } sb_t;

    vec_t vecs [7];
    sb_t  sb [$];
    int   checks = 0;
    int   errors = 0;

    block_t  b_abc, b_empty, b_two1, b_two2;
    digest_t dig_abc, dig_empty, dig_two, dig_dbl;

    function automatic digest_t dg(input logic [255:0] x);
        digest_t r;
        for (int i = 0; i < 8; i++) r[i] = x[255 - 32*i -: 32];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic send(input int d, input block_t b, input bit f, input bit l, input bit db);
        bit ok;
        ok = 1'b0;
        vin[d] = 1'b1; blk[d] = b; fst[d] = f; lst[d] = l; dbl[d] = db;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (rout[d]) begin
                ok = 1'b1;
                @(posedge clk); #1;
            end
        end
        vin[d] = 1'b0; fst[d] = 1'b0; lst[d] = 1'b0; dbl[d] = 1'b0;
        chk($sformatf("accept dut%0d", d), ok, 1'b1);
    endtask

    task automatic wait_out(input int d, output int edges, output bit rdy_seen);
        edges = 0;
        rdy_seen = 1'b0;
        while (!vout[d] && edges < 400) begin
            @(posedge clk); #1;
            edges++;
            if (rout[d]) rdy_seen = 1'b1;
        end
    endtask

    task automatic collect(input int d);
        int  edges;
        bit  rs;
        sb_t e;
        wait_out(d, edges, rs);
        if (sb.size() == 0) begin
            chk("scoreboard empty", 1'b1, 1'b0);
            return;
        end
        e = sb.pop_front();
        chk($sformatf("validOut dut%0d msg%0d", d, e.id), vout[d], 1'b1);
        chk($sformatf("hashOut dut%0d msg%0d", d, e.id), hout[d], e.hash);
        chk($sformatf("latency dut%0d msg%0d", d, e.id), edges, e.lat);
        chk($sformatf("readyOut during compress dut%0d msg%0d", d, e.id), rs, 1'b0);
        if (rin[d]) begin
            @(posedge clk); #1;
            chk($sformatf("validOut one cycle dut%0d msg%0d", d, e.id), vout[d], 1'b0);
            chk($sformatf("readyOut after output dut%0d msg%0d", d, e.id), rout[d], 1'b1);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            vin[i] = 1'b0; fst[i] = 1'b0; lst[i] = 1'b0; dbl[i] = 1'b0; rin[i] = 1'b1; blk[i] = '0;
        end

        b_abc = '0;   b_abc[0] = 32'h61626380;   b_abc[15] = 32'h00000018;
        b_empty = '0; b_empty[0] = 32'h80000000;
        b_two1[0]  = 32'h61626364; b_two1[1]  = 32'h62636465; b_two1[2]  = 32'h63646566; b_two1[3]  = 32'h64656667;
        b_two1[4]  = 32'h65666768; b_two1[5]  = 32'h66676869; b_two1[6]  = 32'h6768696a; b_two1[7]  = 32'h68696a6b;
        b_two1[8]  = 32'h696a6b6c; b_two1[9]  = 32'h6a6b6c6d; b_two1[10] = 32'h6b6c6d6e; b_two1[11] = 32'h6c6d6e6f;
        b_two1[12] = 32'h6d6e6f70; b_two1[13] = 32'h6e6f7071; b_two1[14] = 32'h80000000; b_two1[15] = 32'h00000000;
        b_two2 = '0;  b_two2[15] = 32'h000001c0;

        dig_abc   = dg(256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad);
        dig_two   = dg(256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1);
        dig_dbl   = dg(256'h4f8b42c2_2dd3729b_519ba6f6_8d2da7cc_5b2d606d_05daed5a_d5128cc0_3e6c6358);
        dig_empty = dg(256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855);

        vecs[0] = '{d: 0, b: b_abc,   f: 1'b1, l: 1'b1, db: 1'b0, exp: dig_abc,   lat: 65};
        vecs[1] = '{d: 0, b: b_abc,   f: 1'b1, l: 1'b1, db: 1'b1, exp: dig_dbl,   lat: 130};
        vecs[2] = '{d: 0, b: b_empty, f: 1'b1, l: 1'b1, db: 1'b0, exp: dig_empty, lat: 65};
        vecs[3] = '{d: 1, b: b_empty, f: 1'b1, l: 1'b1, db: 1'b0, exp: dig_empty, lat: 17};
        vecs[4] = '{d: 1, b: b_abc,   f: 1'b1, l: 1'b1, db: 1'b1, exp: dig_abc,   lat: 17};
        vecs[5] = '{d: 2, b: b_empty, f: 1'b1, l: 1'b1, db: 1'b0, exp: dig_empty, lat: 2};
        vecs[6] = '{d: 2, b: b_abc,   f: 1'b1, l: 1'b1, db: 1'b0, exp: dig_abc,   lat: 2};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset validOut dut%0d", i), vout[i], 1'b0);
            chk($sformatf("reset hashOut dut%0d", i), hout[i], '0);
            chk($sformatf("reset readyOut dut%0d", i), rout[i], 1'b0);
            chk($sformatf("reset busyOut dut%0d", i), busy[i], 1'b0);
        end
        resetN = 1'b1;
        #1;
        chk("readyOut after reset release", rout[0], 1'b1);

        // Single-block table
        for (int v = 0; v < 7; v++) begin
            send(vecs[v].d, vecs[v].b, vecs[v].f, vecs[v].l, vecs[v].db);
            sb.push_back('{d: vecs[v].d, id: v, hash: vecs[v].exp, lat: vecs[v].lat});
            collect(vecs[v].d);
        end

        // Two-block message with idle gap; doubleIn on the non-last block is ignored
        begin
            bit rdy_bad;
            rdy_bad = 1'b0;
            send(0, b_two1, 1'b1, 1'b0, 1'b1);
            for (int i = 0; i < 64; i++) begin
                @(posedge clk); #1;
                if (rout[0] || vout[0]) rdy_bad = 1'b1;
            end
            chk("two-block first block busy", rdy_bad, 1'b0);
            @(posedge clk); #1;
            chk("two-block first block done", rout[0], 1'b1);
            repeat (5) @(posedge clk);
            #1;
            chk("two-block gap no output", vout[0], 1'b0);
            send(0, b_two2, 1'b0, 1'b1, 1'b0);
            sb.push_back('{d: 0, id: 100, hash: dig_two, lat: 65});
            collect(0);
        end

        // Backpressure on the R=4 build
        begin
            int  edges;
            bit  rs;
            sb_t e;
            rin[1] = 1'b0;
            send(1, b_empty, 1'b1, 1'b1, 1'b0);
            sb.push_back('{d: 1, id: 200, hash: dig_empty, lat: 17});
            wait_out(1, edges, rs);
            e = sb.pop_front();
            chk("bp hashOut", hout[1], e.hash);
            chk("bp latency", edges, e.lat);
            for (int i = 0; i < 10; i++) begin
                vin[1] = i[0]; blk[1] = b_abc; fst[1] = 1'b1; lst[1] = 1'b1;
                @(posedge clk); #1;
                chk($sformatf("bp validOut hold %0d", i), vout[1], 1'b1);
                chk($sformatf("bp hashOut hold %0d", i), hout[1], e.hash);
                chk($sformatf("bp readyOut low %0d", i), rout[1], 1'b0);
            end
            vin[1] = 1'b0; fst[1] = 1'b0; lst[1] = 1'b0;
            rin[1] = 1'b1;
            @(posedge clk); #1;
            chk("bp validOut drop", vout[1], 1'b0);
            repeat (3) @(posedge clk);
            #1;
            chk("bp pulses not accepted", busy[1], 1'b0);
        end

        // Reset mid-compress abandons the message
        begin
            bit seen;
            seen = 1'b0;
            send(0, b_abc, 1'b1, 1'b1, 1'b0);
            repeat (20) @(posedge clk);
            #1;
            resetN = 1'b0;
            #1;
            chk("readyOut while reset low", rout[0], 1'b0);
            @(posedge clk); #1;
            chk("mid-reset busyOut", busy[0], 1'b0);
            resetN = 1'b1;
            #1;
            chk("mid-reset readyOut after release", rout[0], 1'b1);
            for (int i = 0; i < 100; i++) begin
                @(posedge clk); #1;
                if (vout[0]) seen = 1'b1;
            end
            chk("mid-reset no digest", seen, 1'b0);
            send(0, b_abc, 1'b1, 1'b1, 1'b0);
            sb.push_back('{d: 0, id: 300, hash: dig_abc, lat: 65});
            collect(0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
